// File: rtl/bullet_slot_scheduler.sv
// ---------------------------------------------------------------------------
// bullet_slot_scheduler
//
// Shares a fixed pool of on-screen bullet slots between several fire
// requesters (player cannon, monster rows). A round-robin arbiter picks at most
// one requester per cycle and the lowest-index free slot is loaded with that
// requester's spawn position and direction. Every movement tick, live bullets
// step vertically by STEP pixels. A bullet is freed when it would leave the
// visible area or when the collision logic kills it.
//
// Optional build macro: BULLET_FIRE_COUNT_EN adds a saturating 16-bit count of
// grants on output fire_count.
//
// Ports:
//   ClkPort     in   system clock (100 MHz)
//   Reset       in   asynchronous, active-high reset
//   req         in   [NUM_REQ]      fire request level per requester, held until granted
//   req_x       in   [10*NUM_REQ]   spawn column, requester i at [10i+9:10i]
//   req_y       in   [10*NUM_REQ]   spawn row, same packing
//   req_dir     in   [NUM_REQ]      1 = moves up (y decreasing), 0 = moves down
//   kill        in   [NUM_SLOTS]    one-cycle pulse from collision detector, frees slot
//   grant       out  [NUM_REQ]      one-hot, one-cycle grant pulse
//   slot_valid  out  [NUM_SLOTS]    slot occupied
//   slot_x      out  [10*NUM_SLOTS] bullet column (hold last value when freed)
//   slot_y      out  [10*NUM_SLOTS] bullet row    (hold last value when freed)
//   full        out  1              every slot occupied
//   tick        out  1              one-cycle pulse per movement step
//   fire_count  out  [16]           total grants, saturating (BULLET_FIRE_COUNT_EN only)
// ---------------------------------------------------------------------------
module bullet_slot_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_SLOTS = 4,
    parameter int TICK_DIV  = 20,
    parameter int STEP      = 4,
    parameter int Y_MAX     = 479
) (
    input  logic                    ClkPort,
    input  logic                    Reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [10*NUM_REQ-1:0]   req_x,
    input  logic [10*NUM_REQ-1:0]   req_y,
    input  logic [NUM_REQ-1:0]      req_dir,
    input  logic [NUM_SLOTS-1:0]    kill,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_SLOTS-1:0]    slot_valid,
    output logic [10*NUM_SLOTS-1:0] slot_x,
    output logic [10*NUM_SLOTS-1:0] slot_y,
    output logic                    full,
    output logic                    tick
`ifdef BULLET_FIRE_COUNT_EN
    ,
    output logic [15:0]             fire_count
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [TICK_DIV-1:0]  tick_cnt;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   cand, win_oh, grant_d;
    logic                 win_found, do_grant, slot_found;
    logic [NUM_SLOTS-1:0] alloc_oh, valid_d, dir_q, dir_d;
    logic [9:0]           spawn_x, spawn_y;
    logic                 spawn_dir;
    logic [9:0]           x_q [NUM_SLOTS];
    logic [9:0]           y_q [NUM_SLOTS];
    logic [9:0]           x_d [NUM_SLOTS];
    logic [9:0]           y_d [NUM_SLOTS];

    // NOTE: every variable written here gets a default at the top of the block,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        // A requester granted last cycle is skipped so it has a cycle to drop req.
        cand      = req & ~grant;
        win_oh    = '0;
        win_found = 1'b0;
        // Round-robin: first pass covers indices at/after the pointer, the
        // second pass wraps around to the lowest index.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && cand[i] && (PTR_W'(i) >= ptr_q)) begin
                win_oh[i] = 1'b1;
                win_found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && cand[i]) begin
                win_oh[i] = 1'b1;
                win_found = 1'b1;
            end
        end

        // Free-slot test uses registered state only, so a slot freed this
        // cycle is not reused until the next one.
        do_grant = win_found && !(&slot_valid);
        grant_d  = do_grant ? win_oh : '0;

        spawn_x   = '0;
        spawn_y   = '0;
        spawn_dir = 1'b0;
        ptr_d     = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                spawn_x   = req_x[10*i +: 10];
                spawn_y   = req_y[10*i +: 10];
                spawn_dir = req_dir[i];
                if (do_grant) begin
                    ptr_d = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
                end
            end
        end

        alloc_oh   = '0;
        slot_found = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (!slot_found && !slot_valid[s]) begin
                alloc_oh[s] = do_grant;
                slot_found  = 1'b1;
            end
        end

        // Per-slot priority: allocation, then kill, then movement.
        for (int s = 0; s < NUM_SLOTS; s++) begin
            valid_d[s] = slot_valid[s];
            x_d[s]     = x_q[s];
            y_d[s]     = y_q[s];
            dir_d[s]   = dir_q[s];
            if (alloc_oh[s]) begin
                valid_d[s] = 1'b1;
                x_d[s]     = spawn_x;
                y_d[s]     = spawn_y;
                dir_d[s]   = spawn_dir;
            end else if (kill[s]) begin
                valid_d[s] = 1'b0;
            end else if (tick && slot_valid[s]) begin
                if (dir_q[s]) begin
                    if (y_q[s] < 10'(STEP)) valid_d[s] = 1'b0;
                    else                    y_d[s]     = y_q[s] - 10'(STEP);
                end else begin
                    // 11-bit sum so a bullet near the bottom cannot wrap to the top.
                    if (({1'b0, y_q[s]} + 11'(STEP)) > 11'(Y_MAX)) valid_d[s] = 1'b0;
                    else                                           y_d[s]     = y_q[s] + 10'(STEP);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            tick_cnt   <= '0;
            tick       <= 1'b0;
            ptr_q      <= '0;
            grant      <= '0;
            slot_valid <= '0;
            full       <= 1'b0;
            dir_q      <= '0;
            // NOTE: the slot position array is a handful of flops, not a RAM,
            // and its contents are visible on slot_x/slot_y, so it is reset.
            for (int s = 0; s < NUM_SLOTS; s++) begin
                x_q[s] <= '0;
                y_q[s] <= '0;
            end
        end else begin
            tick_cnt   <= tick_cnt + TICK_DIV'(1);
            tick       <= &tick_cnt;
            ptr_q      <= ptr_d;
            grant      <= grant_d;
            slot_valid <= valid_d;
            full       <= &valid_d;
            dir_q      <= dir_d;
            x_q        <= x_d;
            y_q        <= y_d;
        end
    end

    always_comb begin
        slot_x = '0;
        slot_y = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            slot_x[10*s +: 10] = x_q[s];
            slot_y[10*s +: 10] = y_q[s];
        end
    end

`ifdef BULLET_FIRE_COUNT_EN
    logic [15:0] fire_cnt_q;

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            fire_cnt_q <= '0;
        end else if (do_grant && (fire_cnt_q != 16'hFFFF)) begin
            fire_cnt_q <= fire_cnt_q + 16'd1;
        end
    end

    assign fire_count = fire_cnt_q;
`endif

endmodule

// File: tb/tb_bullet_slot_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bullet_slot_scheduler
//
// Self-checking bench for bullet_slot_scheduler (NUM_REQ=4, NUM_SLOTS=4,
// TICK_DIV=4, STEP=4, Y_MAX=479). A behavioural model written directly from
// the scheduling rules tracks the expected state of every output each cycle.
// A vector table covers arbitration and back-pressure, hand-written sequences
// cover reset, movement/exit and simultaneous events, and a random phase
// covers the rest. Define BULLET_FIRE_COUNT_EN to also check fire_count.
// ---------------------------------------------------------------------------
module tb_bullet_slot_scheduler;

    localparam int NR   = 4;
    localparam int NS   = 4;
    localparam int TD   = 4;
    localparam int STEP = 4;
    localparam int YMAX = 479;

    logic              ClkPort = 1'b0;
    logic              Reset   = 1'b0;
    logic [NR-1:0]     req     = '0;
    logic [10*NR-1:0]  req_x   = '0;
    logic [10*NR-1:0]  req_y   = '0;
    logic [NR-1:0]     req_dir = '0;
    logic [NS-1:0]     kill    = '0;
    logic [NR-1:0]     grant;
    logic [NS-1:0]     slot_valid;
    logic [10*NS-1:0]  slot_x;
    logic [10*NS-1:0]  slot_y;
    logic              full;
    logic              tick;
`ifdef BULLET_FIRE_COUNT_EN
    logic [15:0]       fire_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bullet_slot_scheduler #(
        .NUM_REQ  (NR),
        .NUM_SLOTS(NS),
        .TICK_DIV (TD),
        .STEP     (STEP),
        .Y_MAX    (YMAX)
    ) dut (
        .ClkPort   (ClkPort),
        .Reset     (Reset),
        .req       (req),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_dir   (req_dir),
        .kill      (kill),
        .grant     (grant),
        .slot_valid(slot_valid),
        .slot_x    (slot_x),
        .slot_y    (slot_y),
        .full      (full),
        .tick      (tick)
`ifdef BULLET_FIRE_COUNT_EN
        ,
        .fire_count(fire_count)
`endif
    );

    always #5 ClkPort = ~ClkPort;

    // ---------------- reference model ----------------
    bit m_valid [NS];
    int m_x     [NS];
    int m_y     [NS];
    bit m_dir   [NS];
    int m_ptr;
    int m_last;     // requester granted in the cycle just ended, -1 if none
    int m_cnt;
    bit m_tick;
    int m_fire;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_valid[s] = 1'b0;
            m_x[s]     = 0;
            m_y[s]     = 0;
            m_dir[s]   = 1'b0;
        end
        m_ptr  = 0;
        m_last = -1;
        m_cnt  = 0;
        m_tick = 1'b0;
        m_fire = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        int win  = -1;
        int slot = -1;
        for (int s = 0; s < NS; s++)
            if (slot < 0 && !m_valid[s]) slot = s;
        if (slot >= 0) begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (win < 0 && req[i] && i != m_last) win = i;
            end
        end
        for (int s = 0; s < NS; s++) begin
            if (win >= 0 && s == slot) begin
                m_valid[s] = 1'b1;
                m_x[s]     = int'((req_x >> (10 * win)) & 40'h3FF);
                m_y[s]     = int'((req_y >> (10 * win)) & 40'h3FF);
                m_dir[s]   = req_dir[win];
            end else if (kill[s]) begin
                m_valid[s] = 1'b0;
            end else if (m_tick && m_valid[s]) begin
                if (m_dir[s]) begin
                    if (m_y[s] < STEP) m_valid[s] = 1'b0;
                    else               m_y[s] = m_y[s] - STEP;
                end else begin
                    if (m_y[s] + STEP > YMAX) m_valid[s] = 1'b0;
                    else                      m_y[s] = m_y[s] + STEP;
                end
            end
        end
        m_tick = (m_cnt == (1 << TD) - 1);
        m_cnt  = (m_cnt + 1) % (1 << TD);
        m_last = win;
        if (win >= 0) begin
            m_ptr = (win + 1) % NR;
            if (m_fire < 65535) m_fire++;
        end
    endtask

    task automatic compare_all();
        logic [NS-1:0] ev;
        bit            all_v;
        ev    = '0;
        all_v = 1'b1;
        for (int s = 0; s < NS; s++) begin
            ev[s] = m_valid[s];
            if (!m_valid[s]) all_v = 1'b0;
        end
        check("grant", 32'(grant), (m_last >= 0) ? (32'd1 << m_last) : 32'd0);
        check("slot_valid", 32'(slot_valid), 32'(ev));
        check("full", 32'(full), 32'(all_v));
        check("tick", 32'(tick), 32'(m_tick));
        for (int s = 0; s < NS; s++) begin
            check($sformatf("slot_x[%0d]", s), 32'(slot_x[10*s +: 10]), 32'(m_x[s]));
            check($sformatf("slot_y[%0d]", s), 32'(slot_y[10*s +: 10]), 32'(m_y[s]));
        end
`ifdef BULLET_FIRE_COUNT_EN
        check("fire_count", 32'(fire_count), 32'(m_fire));
`endif
    endtask

    // One clock: model and DUT advance together, outputs compared 1 ns after the edge.
    task automatic step();
        model_update();
        @(posedge ClkPort);
        #1;
        compare_all();
    endtask

    task automatic fire(input int r, input int x, input int y, input bit dir);
        req_x[10*r +: 10] = 10'(x);
        req_y[10*r +: 10] = 10'(y);
        req_dir[r]        = dir;
        req[r]            = 1'b1;
        step();
        check($sformatf("fire_grant_r%0d", r), 32'(grant), 32'd1 << r);
        req[r] = 1'b0;
    endtask

    // Leaves the bench inside a cycle where tick is high.
    task automatic wait_for_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("tick_within_budget", 32'(tick), 32'd1);
    endtask

    typedef struct {
        logic [NR-1:0] req;
        logic [NS-1:0] kill;
        logic [NR-1:0] grant;
        logic [NS-1:0] valid;
        logic          full;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Arbitration and back-pressure, starting straight out of reset.
        tbl[0] = '{4'b1111, 4'b0000, 4'b0001, 4'b0001, 1'b0};
        tbl[1] = '{4'b1110, 4'b0000, 4'b0010, 4'b0011, 1'b0};
        tbl[2] = '{4'b1100, 4'b0000, 4'b0100, 4'b0111, 1'b0};
        tbl[3] = '{4'b1000, 4'b0000, 4'b1000, 4'b1111, 1'b1};
        tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b1};
        tbl[5] = '{4'b0100, 4'b0000, 4'b0000, 4'b1111, 1'b1};  // full: req[2] waits
        tbl[6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1101, 1'b0};  // kill slot 1
        tbl[7] = '{4'b0100, 4'b0000, 4'b0100, 4'b1111, 1'b1};  // slot 1 reused next cycle

        for (int r = 0; r < NR; r++) begin
            req_x[10*r +: 10] = 10'(100 + 37 * r);
            req_y[10*r +: 10] = 10'(200 + 11 * r);
            req_dir[r]        = 1'(r % 2);
        end

        // Power-on reset.
        #1 Reset = 1'b1;
        #1;
        check("rst_slot_valid", 32'(slot_valid), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_slot_x", 32'(slot_x[31:0]), 32'd0);
        check("rst_slot_y", 32'(slot_y[31:0]), 32'd0);
        model_reset();
        @(negedge ClkPort);
        Reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            req  = tbl[i].req;
            kill = tbl[i].kill;
            step();
            check($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
            check($sformatf("tbl%0d_valid", i), 32'(slot_valid), 32'(tbl[i].valid));
            check($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].full));
            kill = '0;
        end
        req = '0;
        check("reuse_slot1_x", 32'(slot_x[19:10]), 32'd174);
        check("reuse_slot1_y", 32'(slot_y[19:10]), 32'd222);

        // Reset mid-flight, while a grant pulse is high: clears immediately.
        #2 Reset = 1'b1;
        #1;
        check("midrst_slot_valid", 32'(slot_valid), 32'd0);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_full", 32'(full), 32'd0);
        model_reset();
        @(negedge ClkPort);
        Reset = 1'b0;

        // Counter restarts at 0: tick rises on the 16th edge after release,
        // i.e. it is high during the 17th cycle.
        begin
            int cyc = 0;
            while (tick !== 1'b1 && cyc < 40) begin
                step();
                cyc++;
            end
            check("first_tick_edges", 32'(cyc), 32'd16);
        end

        // Allocation on a tick cycle: spawn y is kept, then moves up and exits.
        fire(0, 50, 9, 1'b1);
        check("alloc_on_tick_y", 32'(slot_y[9:0]), 32'd9);
        wait_for_tick(); step();
        check("up_y5", 32'(slot_y[9:0]), 32'd5);
        wait_for_tick(); step();
        check("up_y1", 32'(slot_y[9:0]), 32'd1);
        wait_for_tick(); step();
        check("up_exit_valid", 32'(slot_valid[0]), 32'd0);

        // Downward bullet: 472 -> 476, then 480 > 479 frees it.
        fire(1, 60, 472, 1'b0);
        wait_for_tick(); step();
        check("down_y476", 32'(slot_y[9:0]), 32'd476);
        check("down_live", 32'(slot_valid[0]), 32'd1);
        wait_for_tick(); step();
        check("down_exit_valid", 32'(slot_valid[0]), 32'd0);
        check("down_exit_y_held", 32'(slot_y[9:0]), 32'd476);

        // Kill and tick in the same cycle: freed, not moved.
        fire(2, 70, 300, 1'b1);
        wait_for_tick();
        kill = 4'b0001;
        step();
        kill = '0;
        check("kill_tick_valid", 32'(slot_valid[0]), 32'd0);
        check("kill_tick_y", 32'(slot_y[9:0]), 32'd300);

        // A requester that keeps req high is skipped for one cycle after its grant.
        req_y[39:30] = 10'd100;
        req[3] = 1'b1;
        step();
        check("excl_first", 32'(grant), 32'b1000);
        step();
        check("excl_skip", 32'(grant), 32'b0000);
        step();
        check("excl_again", 32'(grant), 32'b1000);
        req = '0;

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            req  = 4'($urandom_range(0, 15));
            kill = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            for (int r = 0; r < NR; r++) begin
                req_x[10*r +: 10] = 10'($urandom_range(0, 1023));
                case ($urandom_range(0, 3))
                    0:       req_y[10*r +: 10] = 10'($urandom_range(0, 12));
                    1:       req_y[10*r +: 10] = 10'($urandom_range(466, 479));
                    default: req_y[10*r +: 10] = 10'($urandom_range(0, 479));
                endcase
                req_dir[r] = 1'($urandom_range(0, 1));
            end
            step();
        end
        req  = '0;
        kill = '0;

`ifdef BULLET_FIRE_COUNT_EN
        // Free everything, preload the counter near the top and check saturation.
        kill = '1;
        step();
        kill = '0;
        force dut.fire_cnt_q = 16'hFFFE;
        #1;
        release dut.fire_cnt_q;
        m_fire = 65534;
        fire(0, 10, 200, 1'b1);
        check("fire_count_top", 32'(fire_count), 32'hFFFF);
        fire(1, 20, 200, 1'b1);
        check("fire_count_sat", 32'(fire_count), 32'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
